imem_loader: RTL
================

Name: imem_loader

Overview:
- Write-side companion to the instruction fetch path.
- Receives a framed program image as a byte stream (e.g. from a UART receiver) and writes 32-bit instruction words into instruction BRAM write port A.
- Then invalidates all instruction-cache lines by writing zeros to every line, and releases the processor from hold.
- Holds the CPU for the whole load and reports done or error.

Parameters:
- ADDR_W, 10, instruction memory word-address width; capacity 2**ADDR_W words.
- SYNC_BYTE, 8'hA5, frame start byte.
- CACHE_LINES, 32, number of cache lines walked during flush; cache index width is log2(CACHE_LINES).
- TIMEOUT_CYCLES, 1000000, maximum idle cycles between accepted bytes inside a frame.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte.
- mem_we  out  1  instruction BRAM port A write enable.
- mem_addr  out  ADDR_W  BRAM port A word address.
- mem_wdata  out  32  BRAM port A write data.
- cache_we  out  1  cache line write enable (flush).
- cache_addr  out  5  cache line index (log2 CACHE_LINES).
- cache_wdata  out  38  cache line data; always 38'd0 (valid bit = 0).
- cpu_hold  out  1  keep pipeline held (PC_en/IF_en low).
- done  out  1  last load succeeded.
- error  out  1  last load failed.

Behaviour:
- Reset values (asynchronous, on reset_n low): state IDLE, rx_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cache_we=0, cache_addr=0, cpu_hold=1, done=0, error=0, all counters and checksum 0. Reset asserted mid-frame or mid-flush aborts immediately; no further writes.
- Handshake: a byte is accepted on a rising edge with rx_valid & rx_ready. rx_ready=1 in IDLE, CNT_LO, CNT_HI, DATA, CHECK, ERROR, DONE; rx_ready=0 in FLUSH.
- Frame format: SYNC_BYTE, count low byte, count high byte (16-bit word count N), 4*N payload bytes (each word little-endian), checksum byte = XOR of all payload bytes.
- IDLE/DONE/ERROR: accepting SYNC_BYTE goes to CNT_LO. It clears done, error and checksum, and asserts cpu_hold. Any other byte is accepted and discarded with no state change.
- CNT_LO -> CNT_HI on accept.
- CNT_HI on accept:
  - N > 2**ADDR_W -> ERROR.
  - N == 0 -> CHECK.
  - Otherwise -> DATA, with word index 0 and byte lane 0.
- DATA:
  - Each accepted byte goes into lane 0..3 (lane 0 = bits 7:0) and is XORed into the checksum.
  - On the lane-3 accept, the next cycle drives mem_we=1 for exactly one cycle, with mem_addr = word index and mem_wdata = assembled word. The word index then increments.
  - After word N-1 is assembled -> CHECK.
  - Back-to-back bytes every cycle are supported; no byte is dropped.
- CHECK on accept:
  - byte == checksum -> FLUSH, with cache_addr=0.
  - Otherwise -> ERROR.
  - Words already written are not undone.
- FLUSH:
  - cache_we=1 for CACHE_LINES consecutive cycles, cache_addr counting 0..CACHE_LINES-1, cache_wdata=0.
  - Then -> DONE.
- DONE: cpu_hold=0, done=1. Both hold until the next SYNC_BYTE.
- ERROR: cpu_hold=1, error=1. Both hold until the next SYNC_BYTE.
- Timeout: in CNT_LO, CNT_HI, DATA or CHECK, a cycle counter resets on every accept. On reaching TIMEOUT_CYCLES with no accept -> ERROR.
- A SYNC_BYTE value received inside a frame is treated as data (no resync).
- mem_we and cache_we are never asserted in the same cycle. mem_we is never asserted outside DATA or the cycle after it.

Test Plan:
- Frame A5 02 00 13 00 00 00 33 00 00 00 20 with rx_valid held high:
  - mem_we pulses twice: addr 0 data 32'h00000013, then addr 1 data 32'h00000033.
  - Then cache_we high for 32 cycles, addr 0..31, data 0.
  - Then done=1, cpu_hold=0, error=0.
- Same frame with checksum 21 -> both words written, no cache_we pulses, error=1, cpu_hold=1; a following A5 clears error.
- Frame A5 00 00 00 (N=0) -> no mem_we, 32 flush cycles, done=1.
- Frame A5 01 04 (N=1025, ADDR_W=10) -> error=1 immediately after count high byte; no mem_we.
- With TIMEOUT_CYCLES=16: send A5 01 00 13, then stall rx_valid for 16 cycles -> error=1; subsequent bytes discarded until A5.
- Assert reset_n low during the flush at cache_addr=10 -> cache_we drops asynchronously, cpu_hold=1, state IDLE; a full valid frame afterwards completes normally.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream program loader: unpacks a framed image into instruction BRAM,
// flushes every cache line, then releases the CPU from hold.
module imem_loader #(
    parameter int         ADDR_W         = 10,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         CACHE_LINES    = 32,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_valid,
    output logic                           rx_ready,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [31:0]                    mem_wdata,
    output logic                           cache_we,
    output logic [$clog2(CACHE_LINES)-1:0] cache_addr,
    output logic [37:0]                    cache_wdata,
    output logic                           cpu_hold,
    output logic                           done,
    output logic                           error
);

    localparam int          CIDX_W    = $clog2(CACHE_LINES);
    localparam int          TMR_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CNT_LO = 3'd1;
    localparam logic [2:0] ST_CNT_HI = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_CHECK  = 3'd4;
    localparam logic [2:0] ST_FLUSH  = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;
    localparam logic [2:0] ST_ERROR  = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [7:0]        count_lo_q, count_lo_d;
    logic [15:0]       words_left_q, words_left_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       shift_q, shift_d;
    logic [7:0]        checksum_q, checksum_d;
    logic [CIDX_W-1:0] cache_idx_q, cache_idx_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic        accept;
    logic        in_frame;
    logic [15:0] frame_len;

    assign accept    = rx_valid && rx_ready;
    assign in_frame  = (state_q == ST_CNT_LO) || (state_q == ST_CNT_HI) ||
                       (state_q == ST_DATA)   || (state_q == ST_CHECK);
    assign frame_len = {rx_data, count_lo_q};

    // Status outputs decode straight from state so an async reset drops them at once.
    assign rx_ready    = (state_q != ST_FLUSH);
    assign cache_we    = (state_q == ST_FLUSH);
    assign cache_addr  = cache_idx_q;
    assign cache_wdata = '0;
    assign cpu_hold    = (state_q != ST_DONE);
    assign done        = (state_q == ST_DONE);
    assign error       = (state_q == ST_ERROR);
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

    always_comb begin
        state_d      = state_q;
        count_lo_d   = count_lo_q;
        words_left_d = words_left_q;
        word_idx_d   = word_idx_q;
        lane_d       = lane_q;
        shift_d      = shift_q;
        checksum_d   = checksum_q;
        cache_idx_d  = cache_idx_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        timer_d      = '0;

        if (in_frame && !accept) begin
            timer_d = timer_q + TMR_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (accept && rx_data == SYNC_BYTE) begin
                    state_d    = ST_CNT_LO;
                    checksum_d = '0;
                end
            end
            ST_CNT_LO: begin
                if (accept) begin
                    count_lo_d = rx_data;
                    state_d    = ST_CNT_HI;
                end
            end
            ST_CNT_HI: begin
                if (accept) begin
                    if ({1'b0, frame_len} > MAX_WORDS) begin
                        state_d = ST_ERROR;
                    end else if (frame_len == 16'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d      = ST_DATA;
                        words_left_d = frame_len;
                        word_idx_d   = '0;
                        lane_d       = '0;
                    end
                end
            end
            ST_DATA: begin
                // Lanes 0..2 shift in from the top; the lane-3 byte completes the word.
                if (accept) begin
                    checksum_d = checksum_q ^ rx_data;
                    lane_d     = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        mem_we_d     = 1'b1;
                        mem_addr_d   = word_idx_q;
                        mem_wdata_d  = {rx_data, shift_q};
                        word_idx_d   = word_idx_q + ADDR_W'(1);
                        words_left_d = words_left_q - 16'd1;
                        if (words_left_q == 16'd1) begin
                            state_d = ST_CHECK;
                        end
                    end else begin
                        shift_d = {rx_data, shift_q[23:8]};
                    end
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    if (rx_data == checksum_q) begin
                        state_d     = ST_FLUSH;
                        cache_idx_d = '0;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_FLUSH: begin
                cache_idx_d = cache_idx_q + CIDX_W'(1);
                if (cache_idx_q == CIDX_W'(CACHE_LINES - 1)) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (in_frame && !accept && timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = ST_ERROR;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            count_lo_q   <= '0;
            words_left_q <= '0;
            word_idx_q   <= '0;
            lane_q       <= '0;
            shift_q      <= '0;
            checksum_q   <= '0;
            cache_idx_q  <= '0;
            timer_q      <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            count_lo_q   <= count_lo_d;
            words_left_q <= words_left_d;
            word_idx_q   <= word_idx_d;
            lane_q       <= lane_d;
            shift_q      <= shift_d;
            checksum_q   <= checksum_d;
            cache_idx_q  <= cache_idx_d;
            timer_q      <= timer_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

endmodule
